// File: rtl/byte_serial_adder_pkg.sv
// Shared definitions for byte_serial_adder.
//   state_t   : FSM encoding (idle, run, done)
//   BYTE_W    : slice width in bits
//   idx_width : byte-index register width for a given byte count (never below 1)
package byte_serial_adder_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    function automatic int unsigned idx_width(input int unsigned nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/cla8_slice.sv
// Combinational 8-bit carry-lookahead adder slice.
// Ports:
//   a, b   : byte operands
//   c_in   : carry into bit 0
//   s      : byte sum
//   c_out  : carry out of bit 7
module cla8_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] s,
    output logic       c_out
);

    logic [7:0] p;
    logic [7:0] g;
    logic [8:0] c;
    logic       acc;
    logic       pr;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat sum of products of generate/propagate terms and c_in,
    // so no carry depends on a lower carry signal.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pr   = 1'b0;
        c[0] = c_in;
        for (int i = 0; i < 8; i++) begin
            acc = g[i];
            pr  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pr & g[j]);
                pr  = pr & p[j];
            end
            acc      = acc | (pr & c_in);
            c[i + 1] = acc;
        end
    end

    assign s     = p ^ c[7:0];
    assign c_out = c[8];

endmodule

// File: rtl/byte_serial_adder.sv
// Sequential wide adder: adds two WIDTH-bit operands one byte per clock through a
// single cla8_slice, linking bytes with a registered carry.
// Optional feature macro: BYTE_SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into a - b - cin (cout = 1 means no borrow).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin [, sub])
//   out_valid / out_ready: result handshake (sum, cout)
//   busy                 : high while an operation is in progress or awaiting pickup
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef BYTE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NBYTES = WIDTH / BYTE_W;
    localparam int unsigned IDX_W  = idx_width(NBYTES);

    if ((WIDTH % BYTE_W) != 0 || WIDTH < BYTE_W) begin : g_bad_width
        $error("byte_serial_adder: WIDTH must be a nonzero multiple of 8");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             sub_q, sub_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             sub_in;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic [7:0]       slice_s;
    logic             slice_c;
    logic             last_byte;

`ifdef BYTE_SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_byte = a_q[k*BYTE_W +: BYTE_W];
                b_byte = b_q[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Subtraction is a + ~b + ~cin; the carry half is folded in at capture time.
    cla8_slice u_slice (
        .a     (a_byte),
        .b     (b_byte ^ {BYTE_W{sub_q}}),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_c)
    );

    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub_in;
                    carry_d = cin ^ sub_in;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k*BYTE_W +: BYTE_W] = slice_s;
                    end
                end
                carry_d = slice_c;
                idx_d   = idx_q + IDX_W'(1);
                if (last_byte) begin
                    cout_d  = slice_c;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder: a WIDTH=32 instance and a WIDTH=8 instance.
module tb_byte_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        sub;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [31:0] a, b, sum;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
    logic [7:0]  a8, b8, sum8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_q[$];
    logic [8:0]  exp8_q[$];

    byte_serial_adder #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef BYTE_SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    byte_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef BYTE_SERIAL_ADDER_SUB_EN
        .sub       (1'b0),
`endif
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .busy      (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb32_unexpected: got %0h expected none", {cout, sum});
            end else begin
                check("sb32_result", {31'b0, cout, sum}, {31'b0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (exp8_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb8_unexpected: got %0h expected none", {cout8, sum8});
            end else begin
                check("sb8_result", {55'b0, cout8, sum8}, {55'b0, exp8_q.pop_front()});
            end
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                         input logic vs);
        a        = va;
        b        = vb;
        cin      = vc;
        sub      = vs;
        in_valid = 1'b1;
        wait_cycle();
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'hCAFE_F00D;
    endtask

    // Waits (bounded) for out_valid after the accept edge; checks latency and that
    // in_ready stays low from the accept edge on.
    task automatic wait_result(input string name);
        int n;
        logic saw_ready;
        n = 0;
        saw_ready = 1'b0;
        do begin
            if (n != 0 || 1'b1) begin
                if (in_ready) saw_ready = 1'b1;
            end
            if (!out_valid) begin
                wait_cycle();
                n++;
            end
        end while (!out_valid && n < 20);
        if (in_ready) saw_ready = 1'b1;
        check({name, "_latency"}, 64'(n), 64'd4);
        check({name, "_in_ready_low"}, {63'b0, saw_ready}, 64'd0);
    endtask

    task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                          input logic vc, input logic vs, input logic [31:0] esum,
                          input logic ecout);
        out_ready = 1'b1;
        exp_q.push_back({ecout, esum});
        issue(va, vb, vc, vs);
        wait_result(name);
        wait_cycle();
        check({name, "_ov_drop"}, {63'b0, out_valid}, 64'd0);
        check({name, "_ready_back"}, {63'b0, in_ready}, 64'd1);
    endtask

    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] esum, input logic ecout);
        int n;
        exp8_q.push_back({ecout, esum});
        a8        = va;
        b8        = vb;
        cin8      = vc;
        in_valid8 = 1'b1;
        wait_cycle();
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 10) begin
            wait_cycle();
            n++;
        end
        check("w8_latency", 64'(n), 64'd1);
        wait_cycle();
        check("w8_ready_back", {63'b0, in_ready8}, 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] rexp;

        rst_n      = 1'b0;
        sub        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        a8         = '0;
        b8         = '0;
        cin8       = 1'b0;
        #1;
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_sum_cout", {31'b0, cout, sum}, 64'd0);
        wait_cycle();
        wait_cycle();
        rst_n = 1'b1;
        wait_cycle();

        // Directed vectors.
        run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        run_op("mixed", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0);
        run_op("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        run_op("bytecarry", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0);

        // Backpressure: result must be held and new operands ignored.
        out_ready = 1'b0;
        exp_q.push_back({1'b1, 32'h0000_0000});
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        wait_result("bp");
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", {63'b0, out_valid}, 64'd1);
            check("bp_sum_cout", {31'b0, cout, sum}, {31'b0, 1'b1, 32'h0});
            check("bp_in_ready", {63'b0, in_ready}, 64'd0);
            in_valid = i[0];
            a        = 32'h5555_5555;
            b        = 32'h3333_3333;
            wait_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_cycle();
        check("bp_ov_drop", {63'b0, out_valid}, 64'd0);
        check("bp_ready_back", {63'b0, in_ready}, 64'd1);

        // Reset after two bytes of RUN: partial result discarded.
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        wait_cycle();
        wait_cycle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("mid_rst_busy", {63'b0, busy}, 64'd0);
        check("mid_rst_sum_cout", {31'b0, cout, sum}, 64'd0);
        wait_cycle();
        rst_n = 1'b1;
        wait_cycle();
        run_op("post_rst", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0);

        // WIDTH=8 instance.
        run8(8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1);
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

        // Random vectors against a + b + cin.
        for (int i = 0; i < 16; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rc   = 1'($urandom_range(1));
            rexp = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            run_op("rand", ra, rb, rc, 1'b0, rexp[31:0], rexp[32]);
        end

`ifdef BYTE_SERIAL_ADDER_SUB_EN
        run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        run_op("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
        run_op("sub_borrow_in", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1);
`endif

        wait_cycle();
        check("sb32_drained", 64'(exp_q.size()), 64'd0);
        check("sb8_drained", 64'(exp8_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
